usr_access_ctrl: RTL and testbench

Controller that qualifies the 32-bit user-access configuration word from the FPGA configuration primitive and shares it between several on-chip requesters. It synchronizes the primitive's valid flag, waits for a settled value, latches it once, then answers read requests through a round-robin arbiter. It sits between the configuration primitive wrapper and the version/ID and register-bank logic.

---
 rtl/usr_access_pkg.sv | 23 ++
 rtl/usr_access_ctrl_if.sv | 26 ++
 rtl/usr_access_ctrl_rr_arbiter.sv | 32 +++
 rtl/usr_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_usr_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usr_access_pkg.sv
// Shared types and constants for the user-access configuration word controller.
package usr_access_pkg;

    // Capture/arbitration phases of the controller.
    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StSettle = 2'd1,
        StReady  = 2'd2,
        StFault  = 2'd3
    } state_e;

    localparam int unsigned SettleW  = 8;
    localparam int unsigned TimeoutW = 16;

    // Word returned to requesters once the controller has given up on the primitive.
    localparam logic [31:0] FaultData = 32'h0;

    // Saturating increment for the timeout counter; it must never wrap back to zero.
    function automatic logic [TimeoutW-1:0] sat_inc(input logic [TimeoutW-1:0] v);
        return (v == '1) ? v : v + TimeoutW'(1);
    endfunction

endpackage

// File: rtl/usr_access_ctrl_if.sv
// Bundle of primitive-facing, requester-facing and broadcast signals of usr_access_ctrl.
interface usr_access_ctrl_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [31:0]        usr_data;
    logic               usr_datavalid;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               word_valid;
    logic [31:0]        word;
    logic               fault;

    // Environment side: drives the primitive outputs and the requests.
    modport master (
        output usr_data, usr_datavalid, req,
        input  rsp_valid, rsp_data, rsp_err, word_valid, word, fault
    );

    // Controller side.
    modport slave (
        input  usr_data, usr_datavalid, req,
        output rsp_valid, rsp_data, rsp_err, word_valid, word, fault
    );
endinterface

// File: rtl/usr_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the last grant.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic            enable,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [PtrW-1:0] ptr_next
);

    logic [PtrW-1:0] idx;
    logic            found;

    // Walk ptr+1 .. ptr+N (mod N); the first active request wins and becomes the new pointer.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = PtrW'((32'(ptr) + off) % N);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_next = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usr_access_ctrl.sv
// Qualifies the configuration primitive's user-access word, latches it once and serves
// it to NUM_REQ requesters through a round-robin arbiter.
module usr_access_ctrl
    import usr_access_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic             clock,
    input logic             reset,
    usr_access_ctrl_if.slave bus
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                dv_m;
    logic                dv_s;
    logic [31:0]         d_q;
    logic [31:0]         d_qq;

    state_e              state_q;
    logic [SettleW-1:0]  settle_q;
    logic [TimeoutW-1:0] tmo_q;
    logic [TimeoutW-1:0] tmo_inc;
    logic                tmo_hit;
    logic                settle_done;
    logic [31:0]         word_q;
    logic                word_valid_q;
    logic                fault_q;

    logic                serving;
    logic [NUM_REQ-1:0]  gnt;
    logic [PtrW-1:0]     rr_ptr_q;
    logic [PtrW-1:0]     rr_ptr_d;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic                rsp_err_q;

    // Bring the asynchronous valid flag into the clock domain; keep current and previous data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dv_m <= 1'b0;
            dv_s <= 1'b0;
            d_q  <= '0;
            d_qq <= '0;
        end else begin
            dv_m <= bus.usr_datavalid;
            dv_s <= dv_m;
            d_q  <= bus.usr_data;
            d_qq <= d_q;
        end
    end

    // Timeout and settle thresholds for the current cycle.
    always_comb begin
        tmo_inc     = sat_inc(tmo_q);
        tmo_hit     = 32'(tmo_inc) >= TIMEOUT_CYCLES;
        settle_done = (32'(settle_q) + 32'd1) >= SETTLE_CYCLES;
    end

    // Capture FSM: wait for valid, require a run of stable samples, then latch once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StWait;
            settle_q     <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                StWait: begin
                    tmo_q <= tmo_inc;
                    if (tmo_hit) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end else if (dv_s) begin
                        state_q  <= StSettle;
                        settle_q <= '0;
                    end
                end
                StSettle: begin
                    // The timeout keeps running across a fallback to StWait.
                    tmo_q <= tmo_inc;
                    if (tmo_hit) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end else if (!dv_s) begin
                        state_q <= StWait;
                    end else if (d_q != d_qq) begin
                        settle_q <= '0;
                    end else if (settle_done) begin
                        word_q       <= d_q;
                        word_valid_q <= 1'b1;
                        state_q      <= StReady;
                    end else begin
                        settle_q <= settle_q + SettleW'(1);
                    end
                end
                StReady, StFault: begin
                    // Terminal until reset; primitive activity is ignored.
                end
                default: state_q <= StWait;
            endcase
        end
    end

    // Requests raised before the word is resolved simply stay pending here.
    assign serving = (state_q == StReady) || (state_q == StFault);

    rr_arbiter #(
        .N    (NUM_REQ),
        .PtrW (PtrW)
    ) u_arb (
        .req      (bus.req),
        .enable   (serving),
        .ptr      (rr_ptr_q),
        .gnt      (gnt),
        .ptr_next (rr_ptr_d)
    );

    // Register the grant as a one-cycle response and advance the round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr_q    <= PtrW'(NUM_REQ - 1);
        end else begin
            rsp_valid_q <= gnt;
            rr_ptr_q    <= rr_ptr_d;
            if (|gnt) begin
                rsp_data_q <= (state_q == StFault) ? FaultData : word_q;
                rsp_err_q  <= (state_q == StFault);
            end else begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word       = word_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_usr_access_ctrl.sv
// Self-checking bench for usr_access_ctrl with a behavioural reference model.
module tb_usr_access_ctrl;

    localparam int NR  = 4;
    localparam int SC  = 8;
    localparam int TC  = 100;
    localparam int Len = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;

    usr_access_ctrl_if #(.NUM_REQ(NR)) bus ();

    usr_access_ctrl #(
        .NUM_REQ        (NR),
        .SETTLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Per-cycle stimulus plan, indexed by cycle number since reset release.
    logic [31:0] data_h [Len];
    logic        dv_h   [Len];
    logic [3:0]  req_h  [Len];
    logic [3:0]  req_cur;
    bit          drop_en;

    // Reference model: abstract progress flags plus expected outputs for the current cycle.
    bit          m_settling, m_ready, m_fault;
    int          m_run, m_tmo, m_last;
    logic [31:0] m_word;
    logic [3:0]  e_rv;
    logic [31:0] e_rd;
    logic        e_re, e_wv, e_f;
    logic [31:0] e_w;

    function automatic logic [70:0] got_vec();
        return {bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.word_valid, bus.word, bus.fault};
    endfunction

    function automatic logic [70:0] exp_vec();
        return {e_rv, e_rd, e_re, e_wv, e_w, e_f};
    endfunction

    task automatic model_reset();
        m_settling = 0; m_ready = 0; m_fault = 0;
        m_run = 0; m_tmo = 0; m_last = NR - 1; m_word = '0;
        e_rv = '0; e_rd = '0; e_re = 0; e_wv = 0; e_w = '0; e_f = 0;
    endtask

    // Predict outputs of cycle k+1 from the inputs seen up to cycle k.
    task automatic model_step(input int k, input logic [3:0] r);
        logic        dvs;
        logic [31:0] dq, dqq;
        logic [3:0]  n_rv;
        logic [31:0] n_rd;
        logic        n_re;
        int          i;
        dvs  = (k >= 2) ? dv_h[k-2] : 1'b0;
        dq   = (k >= 1) ? data_h[k-1] : 32'h0;
        dqq  = (k >= 2) ? data_h[k-2] : 32'h0;
        n_rv = '0; n_rd = '0; n_re = 0;
        if (m_ready || m_fault) begin
            for (int off = 1; off <= NR; off++) begin
                i = (m_last + off) % NR;
                if (n_rv == 4'h0 && r[i]) begin
                    n_rv[i] = 1'b1;
                    m_last  = i;
                    n_rd    = m_fault ? 32'h0 : m_word;
                    n_re    = m_fault;
                end
            end
        end
        if (!m_ready && !m_fault) begin
            m_tmo = (m_tmo < 65535) ? m_tmo + 1 : m_tmo;
            if (m_tmo >= TC) m_fault = 1;
            else if (!m_settling) begin
                if (dvs) begin m_settling = 1; m_run = 0; end
            end else if (!dvs) m_settling = 0;
            else if (dq != dqq) m_run = 0;
            else begin
                m_run++;
                if (m_run == SC) begin m_ready = 1; m_word = dq; end
            end
        end
        e_rv = n_rv; e_rd = n_rd; e_re = n_re; e_wv = m_ready; e_w = m_word; e_f = m_fault;
    endtask

    // Drive this cycle's inputs, advance the model and move to the next cycle (+1 time unit).
    task automatic tick();
        logic [3:0] r;
        r = (req_cur & ~(drop_en ? bus.rsp_valid : 4'h0)) | req_h[cyc];
        req_cur           = r;
        bus.req           = r;
        bus.usr_data      = data_h[cyc];
        bus.usr_datavalid = dv_h[cyc];
        model_step(cyc, r);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0; bus.usr_data = '0; bus.usr_datavalid = 1'b0;
        req_cur = '0; drop_en = 1;
        for (int k = 0; k < Len; k++) begin
            data_h[k] = '0; dv_h[k] = 1'b0; req_h[k] = '0;
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid got=%h exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
        n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid got=%b exp=0", bus.word_valid); end
        n_cmp++; if (bus.word !== 32'h0) begin n_err++; $display("FAIL reset_word got=%h exp=0", bus.word); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            tick();
        end
    endtask

    // Fixed DEADBEEF capture with requester 1 waiting from cycle 5.
    task automatic test_capture();
        do_reset();
        for (int k = 0; k < Len; k++) begin
            data_h[k] = 32'hDEAD_BEEF; dv_h[k] = (k >= 10);
        end
        req_h[5] = 4'b0010;
        for (int k = 0; k < 26; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL capture cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            if (cyc == 20) begin n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL capture_early got=%b exp=0", bus.word_valid); end end
            if (cyc == 21) begin
                n_cmp++; if (bus.word_valid !== 1'b1) begin n_err++; $display("FAIL capture_valid got=%b exp=1", bus.word_valid); end
                n_cmp++; if (bus.word !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL capture_word got=%h exp=deadbeef", bus.word); end
            end
            if (cyc >= 5 && cyc <= 21) begin n_cmp++; if (bus.rsp_valid !== 4'h0) begin n_err++; $display("FAIL pending_early cyc=%0d got=%h exp=0", cyc, bus.rsp_valid); end end
            if (cyc == 22) begin
                n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_err++; $display("FAIL pending_rsp got=%b exp=0010", bus.rsp_valid); end
                n_cmp++; if (bus.rsp_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pending_data got=%h exp=deadbeef", bus.rsp_data); end
                n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL pending_err got=%b exp=0", bus.rsp_err); end
            end
            tick();
        end
    endtask

    // All four requesters held high once the word is ready.
    task automatic test_round_robin();
        logic [31:0] d;
        logic [3:0]  seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        d = $urandom;
        drop_en = 0;
        for (int k = 0; k < Len; k++) begin
            data_h[k] = d; dv_h[k] = 1'b1; req_h[k] = (k >= 11) ? 4'hF : 4'h0;
        end
        for (int k = 0; k < 18; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL rr cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            if (cyc == 11) begin n_cmp++; if (bus.word_valid !== 1'b1) begin n_err++; $display("FAIL rr_ready got=%b exp=1", bus.word_valid); end end
            if (cyc >= 12 && cyc <= 16) begin
                n_cmp++; if (bus.rsp_valid !== seq[cyc-12]) begin n_err++; $display("FAIL rr_seq cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, seq[cyc-12]); end
                n_cmp++; if ({bus.rsp_data, bus.rsp_err} !== {d, 1'b0}) begin n_err++; $display("FAIL rr_data cyc=%0d got=%h/%b exp=%h/0", cyc, bus.rsp_data, bus.rsp_err, d); end
            end
            tick();
        end
    endtask

    // One data change three cycles into settling restarts the stability run.
    task automatic test_data_change();
        logic [31:0] d0, d1;
        do_reset();
        d0 = $urandom;
        d1 = d0 ^ ($urandom | 32'h1);
        for (int k = 0; k < Len; k++) begin
            data_h[k] = (k < 5) ? d0 : d1; dv_h[k] = 1'b1;
        end
        for (int k = 0; k < 18; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL change cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            if (cyc == 14) begin n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL change_early got=%b exp=0", bus.word_valid); end end
            if (cyc == 15) begin
                n_cmp++; if (bus.word_valid !== 1'b1) begin n_err++; $display("FAIL change_valid got=%b exp=1", bus.word_valid); end
                n_cmp++; if (bus.word !== d1) begin n_err++; $display("FAIL change_word got=%h exp=%h", bus.word, d1); end
            end
            tick();
        end
    endtask

    // Valid never arrives; a request raised on the transition cycle gets a fault response.
    task automatic test_timeout();
        do_reset();
        req_h[TC-1] = 4'b0100;
        for (int k = 0; k < TC + 4; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            if (cyc == TC - 1) begin n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL fault_early got=%b exp=0", bus.fault); end end
            if (cyc == TC) begin
                n_cmp++; if ({bus.fault, bus.word_valid} !== 2'b10) begin n_err++; $display("FAIL fault_set got=%b%b exp=10", bus.fault, bus.word_valid); end
            end
            if (cyc == TC + 1) begin
                n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_err++; $display("FAIL fault_rsp got=%b exp=0100", bus.rsp_valid); end
                n_cmp++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL fault_err got=%b/%h exp=1/0", bus.rsp_err, bus.rsp_data); end
            end
            if (cyc == TC + 2) begin n_cmp++; if (bus.rsp_valid !== 4'h0) begin n_err++; $display("FAIL fault_drop got=%b exp=0000", bus.rsp_valid); end end
            tick();
        end
    endtask

    // Reset pulse while serving held requests, then the capture sequence again.
    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        d = $urandom;
        drop_en = 0;
        for (int k = 0; k < Len; k++) begin
            data_h[k] = d; dv_h[k] = 1'b1; req_h[k] = (k >= 11) ? 4'hF : 4'h0;
        end
        for (int k = 0; k < 14; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            tick();
        end
        reset = 1'b1;
        #2;
        n_cmp++; if (got_vec() !== 71'h0) begin n_err++; $display("FAIL mid_reset_outputs got=%h exp=0", got_vec()); end
        do_reset();
        for (int k = 0; k < Len; k++) begin
            data_h[k] = d; dv_h[k] = 1'b1;
        end
        for (int k = 0; k < 14; k++) begin
            n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL mid_post cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec()); end
            if (cyc == 10) begin n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL mid_early got=%b exp=0", bus.word_valid); end end
            if (cyc == 11) begin n_cmp++; if ({bus.word_valid, bus.word} !== {1'b1, d}) begin n_err++; $display("FAIL mid_word got=%b/%h exp=1/%h", bus.word_valid, bus.word, d); end end
            tick();
        end
    endtask

    // Random valid start, data glitches, valid dropouts and request traffic.
    task automatic test_random();
        int          r;
        logic [31:0] cur;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            r   = $urandom_range(0, 15);
            cur = $urandom;
            for (int k = 0; k < Len; k++) begin
                if (k >= r && k < r + 20 && $urandom_range(0, 5) == 0) cur = $urandom;
                data_h[k] = cur;
                dv_h[k]   = (k >= r);
                req_h[k]  = 4'($urandom & $urandom);
            end
            if ($urandom_range(0, 2) == 0) begin dv_h[r+6] = 1'b0; dv_h[r+7] = 1'b0; end
            for (int k = 0; k < 80; k++) begin
                n_cmp++; if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, cyc, got_vec(), exp_vec()); end
                tick();
            end
            n_cmp++; if (bus.word_valid !== 1'b1) begin n_err++; $display("FAIL random_ready it=%0d got=%b exp=1", it, bus.word_valid); end
        end
    endtask

    initial begin
        bus.req = '0; bus.usr_data = '0; bus.usr_datavalid = 1'b0;
        test_reset();
        test_capture();
        test_round_robin();
        test_data_change();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
